// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbitration slice.
// Source indices name the fixed requesters wired into the arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int SRC_ECHO       = 0;
    localparam int SRC_ALU        = 1;
    localparam int SRC_ERR        = 2;
    localparam int TX_ARB_NUM_SRC = 3;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: one-hot first requester above last_grant, wrapping to the bottom.
// Latency: purely combinational.
// Backpressure: none; a pure function of the request vector and pointer.
module uart_tx_arbiter_rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic          any_req
);

    logic [N-1:0] gnt_hi;
    logic [N-1:0] gnt_lo;
    logic         found_hi;
    logic         found_lo;

    // Lowest requester above the pointer wins; otherwise lowest at or below it.
    always_comb begin
        gnt_hi   = '0;
        gnt_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (i > int'(last_grant)) && !found_hi) begin
                gnt_hi[i] = 1'b1;
                found_hi  = 1'b1;
            end
            if (req[i] && (i <= int'(last_grant)) && !found_lo) begin
                gnt_lo[i] = 1'b1;
                found_lo  = 1'b1;
            end
        end
        gnt = found_hi ? gnt_hi : gnt_lo;
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the uart_tx byte sink among NUM_SRC streams.
// Latency: 1-cycle arbitration bubble per packet, then combinational byte pass-through.
// Backpressure: tx_ready_i routed only to the granted source; stall timeout under UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = TX_ARB_NUM_SRC,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_SRC-1:0]            req_valid_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_SRC-1:0]            req_last_i,
    output logic [NUM_SRC-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [NUM_SRC-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int IW = idx_width(NUM_SRC);

    if (NUM_SRC < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: NUM_SRC and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t            state;
    logic [NUM_SRC-1:0]    grant;
    logic [IW-1:0]         last_grant;
    logic                  busy;
    logic [NUM_SRC-1:0]    pick;
    logic [IW-1:0]         pick_idx;
    logic                  any_req;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  fire;
    logic                  revoke;

    uart_tx_arbiter_rr_picker #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_picker (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .gnt        (pick),
        .any_req    (any_req)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // grant is zero outside XFER, so every pass-through term idles at 0 in ARB.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) g_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign g_valid     = |(req_valid_i & grant);
    assign g_last      = |(req_last_i & grant);
    assign fire        = g_valid && tx_ready_i;
    assign tx_valid_o  = g_valid;
    assign tx_data_o   = g_data;
    assign req_ready_o = grant & {NUM_SRC{tx_ready_i}};
    assign grant_o     = grant;
    assign busy_o      = busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB;
            grant      <= '0;
            busy       <= 1'b0;
            last_grant <= IW'(NUM_SRC - 1);
        end else begin
            case (state)
                ARB: begin
                    if (any_req) begin
                        state      <= XFER;
                        grant      <= pick;
                        last_grant <= pick_idx;
                        busy       <= 1'b1;
                    end
                end
                XFER: begin
                    if ((fire && g_last) || revoke) begin
                        state <= ARB;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] stall_cnt;
    logic          timeout_q;

    // Revoke on the TIMEOUT_CYCLES-th consecutive stalled cycle; the packet is dropped unfinished.
    assign revoke = (state == XFER) && !g_valid && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if ((state != XFER) || g_valid || revoke) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign revoke    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table plus queue-driven sources with a byte scoreboard.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_last_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   tx_data_o;
    logic            tx_valid_o;
    logic            tx_ready_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic            timeout_o;

    uart_tx_arbiter #(
        .NUM_SRC        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [DW-1:0] dat;
    } sb_t;

    typedef struct {
        logic [N-1:0]  vld;
        logic [N-1:0]  lst;
        logic [DW-1:0] dat;
        logic          rdy;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rdy;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic          e_busy;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         start;
    int         n;
    int         timeout_cnt;
    int         to_cyc;
    int         off[6];
    sb_t        sb_q[$];
    int         xfer_cyc[$];
    logic [DW:0] src_q[N][$];
    logic [N-1:0] en;

    function automatic vec_t mkv(input logic [N-1:0] vld, input logic [N-1:0] lst,
                                 input logic [DW-1:0] dat, input logic rdy,
                                 input logic [N-1:0] eg, input logic [N-1:0] er,
                                 input logic ev, input logic [DW-1:0] ed, input logic eb);
        vec_t r;
        r.vld = vld; r.lst = lst; r.dat = dat; r.rdy = rdy;
        r.e_gnt = eg; r.e_rdy = er; r.e_vld = ev; r.e_dat = ed; r.e_busy = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int src, input logic [DW-1:0] first, input int len, input int nsb);
        sb_t e;
        for (int i = 0; i < len; i++) begin
            src_q[src].push_back({(i == len - 1), first + DW'(i)});
            if (i < nsb) begin
                e.gnt = N'(1) << src;
                e.dat = first + DW'(i);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic drive();
        logic [DW:0] h;
        for (int k = 0; k < N; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                h = src_q[k][0];
                req_valid_i[k]            = 1'b1;
                req_last_i[k]             = h[DW];
                req_data_i[k*DW +: DW]    = h[DW-1:0];
            end else begin
                req_valid_i[k]            = 1'b0;
                req_last_i[k]             = 1'b0;
                req_data_i[k*DW +: DW]    = '0;
            end
        end
    endtask

    // Called at the negedge: every accepted output byte must match the scoreboard head.
    task automatic monitor();
        sb_t e;
        if (timeout_o) begin
            timeout_cnt++;
            if (to_cyc < 0) to_cyc = cyc;
        end
        if (tx_valid_o && tx_ready_i) begin
            xfer_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %0h from grant %0b, expected no byte", tx_data_o, grant_o);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", tx_data_o, e.dat);
                chk("sb_source", grant_o, e.gnt);
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] fire;
        drive();
        @(negedge clk_i);
        monitor();
        fire = req_valid_i & req_ready_o;
        @(posedge clk_i);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (fire[k]) void'(src_q[k].pop_front());
        end
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            cycle();
            c++;
        end
        chk({name, "_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_valid_i = '0; req_last_i = '0; req_data_i = '0;
        tx_ready_i = 1'b0; en = '0; timeout_cnt = 0; to_cyc = -1;
        off[0] = 1; off[1] = 2; off[2] = 4; off[3] = 5; off[4] = 7; off[5] = 8;

        // src1 4-byte packet at full rate, then src2 3-byte packet under ready 1,0,0,1,0,1.
        vt[0]  = mkv(3'b010, 3'b000, 8'h11, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        vt[1]  = mkv(3'b010, 3'b000, 8'h11, 1'b1, 3'b010, 3'b010, 1'b1, 8'h11, 1'b1);
        vt[2]  = mkv(3'b010, 3'b000, 8'h22, 1'b1, 3'b010, 3'b010, 1'b1, 8'h22, 1'b1);
        vt[3]  = mkv(3'b010, 3'b000, 8'h33, 1'b1, 3'b010, 3'b010, 1'b1, 8'h33, 1'b1);
        vt[4]  = mkv(3'b010, 3'b010, 8'h44, 1'b1, 3'b010, 3'b010, 1'b1, 8'h44, 1'b1);
        vt[5]  = mkv(3'b000, 3'b000, 8'h00, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        vt[6]  = mkv(3'b100, 3'b000, 8'hAA, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        vt[7]  = mkv(3'b100, 3'b000, 8'hAA, 1'b1, 3'b100, 3'b100, 1'b1, 8'hAA, 1'b1);
        vt[8]  = mkv(3'b100, 3'b000, 8'hBB, 1'b0, 3'b100, 3'b000, 1'b1, 8'hBB, 1'b1);
        vt[9]  = mkv(3'b100, 3'b000, 8'hBB, 1'b0, 3'b100, 3'b000, 1'b1, 8'hBB, 1'b1);
        vt[10] = mkv(3'b100, 3'b000, 8'hBB, 1'b1, 3'b100, 3'b100, 1'b1, 8'hBB, 1'b1);
        vt[11] = mkv(3'b100, 3'b100, 8'hCC, 1'b0, 3'b100, 3'b000, 1'b1, 8'hCC, 1'b1);
        vt[12] = mkv(3'b100, 3'b100, 8'hCC, 1'b1, 3'b100, 3'b100, 1'b1, 8'hCC, 1'b1);
        vt[13] = mkv(3'b000, 3'b000, 8'h00, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            sb_t e;
            if (vt[i].e_vld && vt[i].rdy) begin
                e.gnt = vt[i].e_gnt;
                e.dat = vt[i].e_dat;
                sb_q.push_back(e);
            end
        end
        for (int i = 0; i < NV; i++) begin
            req_valid_i = vt[i].vld;
            req_last_i  = vt[i].lst;
            req_data_i  = {N{vt[i].dat}};
            tx_ready_i  = vt[i].rdy;
            @(negedge clk_i);
            monitor();
            chk($sformatf("vec%0d_grant", i), grant_o, vt[i].e_gnt);
            chk($sformatf("vec%0d_req_ready", i), req_ready_o, vt[i].e_rdy);
            chk($sformatf("vec%0d_tx_valid", i), tx_valid_o, vt[i].e_vld);
            chk($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
            chk($sformatf("vec%0d_timeout", i), timeout_o, 0);
            if (vt[i].e_vld) chk($sformatf("vec%0d_tx_data", i), tx_data_o, vt[i].e_dat);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("table_drained", sb_q.size(), 0);

        // Contention from reset: grants 0,1,2 with one idle cycle between packets.
        push_pkt(SRC_ECHO, 8'h01, 2, 2);
        push_pkt(SRC_ALU,  8'h11, 2, 2);
        push_pkt(SRC_ERR,  8'h21, 2, 2);
        en = '1; tx_ready_i = 1'b1; rst_i = 1'b1;
        cycle();
        drive();
        #3;
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;
        xfer_cyc.delete();
        start = cyc;
        run_until_idle(40, "contention");
        chk("contention_xfers", xfer_cyc.size(), 6);
        if (xfer_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("contention_cyc%0d", i), xfer_cyc[i] - start, off[i]);
        end

        // src0 arrives mid-packet while src2 streams 5 bytes; src2 must finish first.
        push_pkt(SRC_ERR,  8'h50, 5, 5);
        push_pkt(SRC_ECHO, 8'h0A, 2, 2);
        en = 3'b100;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            if (src_q[SRC_ERR].size() <= 3) en[SRC_ECHO] = 1'b1;
            cycle();
            n++;
        end
        chk("midpkt_drained", sb_q.size(), 0);
        chk("midpkt_src0_empty", src_q[SRC_ECHO].size(), 0);

        // Reset during byte 2 of a src1 packet; pointer must return to favour src0.
        push_pkt(SRC_ALU, 8'h61, 4, 2);
        en = 3'b010;
        n = 0;
        while (src_q[SRC_ALU].size() > 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("rstmid_first_byte", src_q[SRC_ALU].size(), 3);
        rst_i = 1'b1;
        cycle();
        drive();
        #3;
        chk("rstmid_grant", grant_o, 0);
        chk("rstmid_tx_valid", tx_valid_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_req_ready", req_ready_o, 0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        rst_i = 1'b0;
        push_pkt(SRC_ECHO, 8'h70, 1, 1);
        push_pkt(SRC_ALU,  8'h71, 1, 1);
        push_pkt(SRC_ERR,  8'h72, 1, 1);
        en = '1;
        run_until_idle(30, "post_reset");

        // src0 sends one byte then stalls while src1 waits.
`ifdef UART_TX_ARB_TIMEOUT_EN
        push_pkt(SRC_ECHO, 8'h80, 2, 1);
`else
        push_pkt(SRC_ECHO, 8'h80, 2, 2);
`endif
        push_pkt(SRC_ALU, 8'h90, 1, 1);
        en = 3'b011; timeout_cnt = 0; to_cyc = -1;
        xfer_cyc.delete();
        n = 0;
        while (src_q[SRC_ECHO].size() > 1 && n < 20) begin
            cycle();
            n++;
        end
        en[SRC_ECHO] = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        run_until_idle(40, "timeout");
        chk("timeout_pulses", timeout_cnt, 1);
        chk("timeout_xfer_seen", xfer_cyc.size(), 2);
        if (xfer_cyc.size() >= 1) chk("timeout_cycle", to_cyc - xfer_cyc[0], 9);
        src_q[SRC_ECHO].delete();
`else
        repeat (20) cycle();
        chk("hold_grant", grant_o, 3'b001);
        chk("hold_busy", busy_o, 1);
        chk("hold_no_timeout", timeout_cnt, 0);
        chk("hold_src1_waiting", sb_q.size(), 2);
        en[SRC_ECHO] = 1'b1;
        run_until_idle(20, "hold_release");
        chk("hold_release_no_timeout", timeout_cnt, 0);
`endif
        repeat (2) cycle();
        chk("final_idle_grant", grant_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single uart_tx byte sink between NUM_SRC byte-stream requesters (e.g. echo path, ALU result path, error responder).
- Once a requester is granted, its whole packet (up to and including the byte flagged last) goes out uninterrupted, then the grant rotates.
- Sits between the packet engines and uart_tx; drives uart_tx s_axis_tdata/tvalid and consumes its tready.

Parameters:
- NUM_SRC, 3, number of requesters (>=1).
- DATA_WIDTH, 8, byte width on every stream.
- TIMEOUT_CYCLES, 1024, stall limit used only when the optional feature is compiled in.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_SRC  per-source byte valid.
- req_data_i  input  NUM_SRC*DATA_WIDTH  per-source byte; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  input  NUM_SRC  per-source end-of-packet flag, qualified by valid.
- req_ready_o  output  NUM_SRC  per-source ready.
- tx_data_o  output  DATA_WIDTH  byte to uart_tx.
- tx_valid_o  output  1  valid to uart_tx.
- tx_ready_i  input  1  ready from uart_tx.
- grant_o  output  NUM_SRC  one-hot current owner; all zero when idle.
- busy_o  output  1  high while a packet is owned.
- timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout. Tied 0 without the optional feature.

Behaviour:
- Reset (sync, rst_i=1 at posedge): state ARB, grant_o=0, busy_o=0, timeout_o=0, last_grant pointer=NUM_SRC-1, so source 0 has first priority.
- While reset is asserted and in ARB: tx_valid_o=0, tx_data_o=0, req_ready_o=0.
- State ARB:
  - If any req_valid_i is high, pick the first valid source scanning upward from last_grant+1 (modulo NUM_SRC).
  - Register it into grant_o and last_grant; go to XFER.
  - No bytes pass in ARB; the arbitration bubble is exactly 1 cycle.
- State XFER, combinational pass-through of the granted source g:
  - tx_valid_o=req_valid_i[g], tx_data_o=data[g], req_ready_o[g]=tx_ready_i.
  - All other req_ready_o are 0.
  - A transfer occurs when tx_valid_o and tx_ready_i are both high.
- XFER -> ARB on a transfer with req_last_i[g]=1. grant_o clears and busy_o drops the next cycle.
- Latency: a request seen in cycle t is granted at t+1; its first byte can transfer in cycle t+1 if tx_ready_i=1.
- Fairness: after source g finishes, g has lowest priority in the next arbitration. With all sources continuously requesting, grants rotate 0,1,2,0,...
- Single-byte packet (last on first beat) is legal: XFER lasts one transfer.
- Granted source deasserting valid mid-packet: grant is held indefinitely (without the optional feature). Other sources wait.
- Requests from other sources arriving during XFER are ignored until ARB; no request is ever dropped.
- req_data_i and req_last_i of a non-granted source are don't-care.
- Reset mid-packet: the packet is abandoned. Outputs return to reset values from the cycle after the reset edge, and the pointer resets.
- NUM_SRC=1: degenerates to pass-through with a 1-cycle bubble between packets.
- Sources must hold data and last stable while valid && !ready (AXI-stream rule). The arbiter does not buffer.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - In XFER a counter increments on every cycle where req_valid_i[g]=0, and resets to 0 on any cycle with valid high.
  - When the counter reaches TIMEOUT_CYCLES, the grant is revoked: go to ARB, pulse timeout_o for 1 cycle, clear the counter.
  - The truncated packet is not completed.
- Undefined: no counter logic; timeout_o tied 0; the grant is held until last.

Decomposition:
- config_pkg gains:
  - typedef arb_state_t {ARB, XFER}.
  - Source index constants SRC_ECHO=0, SRC_ALU=1, SRC_ERR=2.
  - Default TX_ARB_NUM_SRC=3.
- One sub-module: rr_picker. It is combinational: inputs are a request vector and last_grant; outputs are one-hot next grant and an any_req flag. It is reusable for a future RX dispatcher.

Test Plan:
- Single source: src1 sends 4-byte packet 0x11,0x22,0x33,0x44(last), tx_ready_i=1 -> grant_o=3'b010 one cycle after valid. The bytes appear on tx_data_o in 4 consecutive cycles, then grant_o=0.
- Contention: src0, src1, src2 all valid from reset with 2-byte packets -> grant order 0,1,2. The output byte stream never interleaves sources. There is exactly one idle cycle between packets.
- Backpressure: tx_ready_i toggles 1,0,0,1,... during a 3-byte src2 packet -> tx_data_o is stable while ready=0. req_ready_o[2] mirrors tx_ready_i. No byte is lost or duplicated.
- Mid-packet arrival: src2 streaming a 5-byte packet, src0 raises valid after byte 2 -> src0 is not granted until src2's last byte transfers, then src0 is granted.
- Reset mid-packet: assert rst_i during byte 2 of src1's packet -> next cycle grant_o=0, tx_valid_o=0. With all sources requesting afterwards, src0 is granted first.
- Timeout (with UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): src0 sends 1 byte then holds valid low -> after 8 stalled cycles timeout_o pulses once and the grant moves to the pending src1. Without the macro, the grant is held and timeout_o stays 0.
